pcs_rx_ecb_rd_ctrl: RTL
=======================

# pcs_rx_ecb_rd_ctrl

Read-side controller for the 32-entry RX elastic (clock-compensation) buffer in the 25G PCS receive path. It takes the write pointer already synchronized into the read domain, gray-decodes and registers it, and computes occupancy against its own read pointer. Each cycle it schedules exactly one action: read, delete (drop an idle entry), insert (emit an idle without consuming), or none. It returns a gray-coded read pointer for synchronization back to the write side.

## Interface
- LOW_WM, 8: occupancy below this allows idle insertion
- HIGH_WM, 24: occupancy above this allows idle deletion
- TARGET, 16: occupancy required to leave FILL
- CC_GAP, 4: minimum cycles between two insert/delete actions
- clk  in  1  read-domain clock
- reset_n  in  1  synchronous, active-high reset (asserted = 1)
- wr_ptr_gray  in  5  synchronized gray write pointer
- head_is_idle  in  1  entry at rd_addr is a deletable idle block
- rd_addr  out  5  binary read pointer (head entry address)
- rd_en  out  1  head entry consumed and valid downstream this cycle
- rd_drop  out  1  head entry consumed and discarded (deletion)
- ins_idle  out  1  downstream receives an inserted idle; no consume
- rd_ptr_gray  out  5  gray of rd_addr, registered
- occupancy  out  5  (wr_bin_q − rd_addr) mod 32
- underflow  out  1  one-cycle pulse
- overflow  out  1  one-cycle pulse
- state  out  2  FILL=0, RUN=1, FLUSH=2

## Operation
- wr_bin_q <= gray2bin(wr_ptr_gray) every cycle. occupancy is computed combinationally from wr_bin_q and rd_addr, with 5-bit wrap. Usable capacity is 31.
- rd_en, rd_drop and ins_idle are Mealy outputs of state, occupancy, head_is_idle and gap_cnt. They are mutually exclusive.
- FILL: no actions. occupancy ≥ TARGET → RUN. occupancy == 31 → FLUSH with an overflow pulse.
- RUN applies the first matching rule:
  1. occupancy == 0 → underflow pulse, no action, next state FILL.
  2. occupancy == 31 → overflow pulse, no action, next state FLUSH.
  3. gap_cnt == 0, head_is_idle, occupancy > HIGH_WM → rd_drop, rd_addr+1, gap_cnt <= CC_GAP.
  4. gap_cnt == 0, head_is_idle, occupancy < LOW_WM → ins_idle, rd_addr held, gap_cnt <= CC_GAP.
  5. Otherwise → rd_en, rd_addr+1.
- FLUSH: rd_addr <= wr_bin_q (empties the buffer), no actions, next state FILL.
- gap_cnt decrements by 1 per cycle while nonzero, in every state.
- rd_addr wraps 31→0.
- rd_ptr_gray is registered from the next value of rd_addr, so it always equals bin2gray(rd_addr) in the same cycle. Only one bit changes per advance.

## Timing
- Reset values: rd_addr=0, wr_bin_q=0, rd_ptr_gray=0, gap_cnt=0, state=FILL. rd_en, rd_drop, ins_idle, underflow and overflow are all 0; occupancy=0.
- A change on wr_ptr_gray is visible on occupancy 1 cycle later.
- An action decided in cycle t updates rd_addr and rd_ptr_gray at edge t+1.
- Peak read rate is 1 entry/cycle. Sustained RUN with a steady writer gives rd_en=1 every cycle.
- When reset is asserted mid-RUN, outputs read the reset values in the following cycle and any pending action is lost. The buffer contents are ignored.
- In FLUSH, a write pointer moving during the flush cycle leaves occupancy at 1–2 on entry to FILL. This is accepted.
- In RUN, occupancy == 0 and ins_idle cannot coincide: underflow wins.

## Structure
- Package pcs_ecb_pkg holds:
  - ADDR_W=5, PTR_MAX=31
  - state enum ecb_state_t {FILL, RUN, FLUSH}
  - function bin2gray5
- Sub-module pcs_gray2bin5: combinational 5-bit gray→binary decoder. It is instantiated once, on wr_ptr_gray, ahead of the wr_bin_q register.
- Remaining logic (state register, gap counter, pointer, rule priority) lives in one always_ff plus one always_comb.

## Test plan
- **Reset and fill.** After reset, step wr_ptr_gray through gray(1..16), one per cycle. Required: no actions during FILL. state=RUN one cycle after occupancy reads 16. rd_en=1 in the first RUN cycle with rd_addr=0.
- **Deletion.** Hold occupancy at 26 with head_is_idle=1. Required: rd_drop in the first cycle, then rd_en for 4 cycles (gap), then rd_drop again. rd_addr advances every cycle.
- **Insertion.** Occupancy 5, head_is_idle=1, writer stalled. Required: ins_idle with rd_addr held, then rd_en×4, then ins_idle once occupancy is still < 8.
- **Underflow.** In RUN, stop the writer at occupancy 3. Required: rd_en×3, then an underflow pulse with occupancy=0, then state=FILL. No rd_en until occupancy reaches 16 again.
- **Overflow and flush.** In FILL, drive wr_ptr_gray=gray(31) with rd_addr=0. Required: overflow pulse, then FLUSH for 1 cycle, then rd_addr=31, occupancy=0, state=FILL.
- **Wrap.** Run across the 31→0 boundary. Required: rd_ptr_gray goes 10000→00000, exactly one bit changes per advance, and occupancy stays correct modulo 32.

Source files
------------

// File: rtl/pcs_ecb_pkg.sv
// Shared types and helpers for the RX elastic-buffer read controller.
package pcs_ecb_pkg;

    localparam int              ADDR_W  = 5;
    localparam logic [ADDR_W-1:0] PTR_MAX = 5'd31;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } ecb_state_t;

    function automatic logic [ADDR_W-1:0] bin2gray5(input logic [ADDR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/pcs_gray2bin5.sv
// Combinational 5-bit gray-to-binary decoder.
module pcs_gray2bin5
    import pcs_ecb_pkg::*;
(
    input  logic [4:0] gray,
    output logic [4:0] bin
);

    // Each binary bit is the XOR of all gray bits at or above it.
    assign bin[4] = gray[4];
    assign bin[3] = ^gray[4:3];
    assign bin[2] = ^gray[4:2];
    assign bin[1] = ^gray[4:1];
    assign bin[0] = ^gray[4:0];

endmodule

// File: rtl/pcs_rx_ecb_rd_ctrl.sv
// Read-side controller of the 32-entry RX clock-compensation buffer:
// occupancy tracking, one read/delete/insert action per cycle, gray read pointer.
module pcs_rx_ecb_rd_ctrl
    import pcs_ecb_pkg::*;
#(
    parameter int LOW_WM  = 8,
    parameter int HIGH_WM = 24,
    parameter int TARGET  = 16,
    parameter int CC_GAP  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] wr_ptr_gray,
    input  logic       head_is_idle,
    output logic [4:0] rd_addr,
    output logic       rd_en,
    output logic       rd_drop,
    output logic       ins_idle,
    output logic [4:0] rd_ptr_gray,
    output logic [4:0] occupancy,
    output logic       underflow,
    output logic       overflow,
    output logic [1:0] state
);

    localparam int GAP_W = (CC_GAP > 0) ? $clog2(CC_GAP + 1) : 1;
    localparam logic [ADDR_W-1:0] LOW_C    = ADDR_W'(LOW_WM);
    localparam logic [ADDR_W-1:0] HIGH_C   = ADDR_W'(HIGH_WM);
    localparam logic [ADDR_W-1:0] TARGET_C = ADDR_W'(TARGET);
    localparam logic [GAP_W-1:0]  GAP_C    = GAP_W'(CC_GAP);

    logic [ADDR_W-1:0] wr_bin_dec;
    logic [ADDR_W-1:0] wr_bin_d, wr_bin_q;
    logic [ADDR_W-1:0] rd_addr_d, rd_addr_q;
    logic [ADDR_W-1:0] rd_ptr_gray_q;
    logic [GAP_W-1:0]  gap_cnt_d, gap_cnt_q;
    ecb_state_t        state_d, state_q;
    logic              cc_ok;

    pcs_gray2bin5 u_wr_g2b (
        .gray (wr_ptr_gray),
        .bin  (wr_bin_dec)
    );

    always_comb begin
        wr_bin_d  = wr_bin_dec;
        occupancy = wr_bin_q - rd_addr_q;
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        gap_cnt_d = (gap_cnt_q != '0) ? gap_cnt_q - 1'b1 : '0;
        rd_en     = 1'b0;
        rd_drop   = 1'b0;
        ins_idle  = 1'b0;
        underflow = 1'b0;
        overflow  = 1'b0;
        cc_ok     = (gap_cnt_q == '0) && head_is_idle;

        case (state_q)
            FILL: begin
                if (occupancy == PTR_MAX) begin
                    overflow = 1'b1;
                    state_d  = FLUSH;
                end else if (occupancy >= TARGET_C) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Empty/full checks take priority over any clock-compensation action.
                if (occupancy == '0) begin
                    underflow = 1'b1;
                    state_d   = FILL;
                end else if (occupancy == PTR_MAX) begin
                    overflow = 1'b1;
                    state_d  = FLUSH;
                end else if (cc_ok && (occupancy > HIGH_C)) begin
                    rd_drop   = 1'b1;
                    rd_addr_d = rd_addr_q + 1'b1;
                    gap_cnt_d = GAP_C;
                end else if (cc_ok && (occupancy < LOW_C)) begin
                    ins_idle  = 1'b1;
                    gap_cnt_d = GAP_C;
                end else begin
                    rd_en     = 1'b1;
                    rd_addr_d = rd_addr_q + 1'b1;
                end
            end
            FLUSH: begin
                rd_addr_d = wr_bin_q;
                state_d   = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            wr_bin_q      <= '0;
            rd_addr_q     <= '0;
            rd_ptr_gray_q <= '0;
            gap_cnt_q     <= '0;
            state_q       <= FILL;
        end else begin
            wr_bin_q      <= wr_bin_d;
            rd_addr_q     <= rd_addr_d;
            rd_ptr_gray_q <= bin2gray5(rd_addr_d);
            gap_cnt_q     <= gap_cnt_d;
            state_q       <= state_d;
        end
    end

    assign rd_addr     = rd_addr_q;
    assign rd_ptr_gray = rd_ptr_gray_q;
    assign state       = state_q;

endmodule
